// File: rtl/avr_io_pkg.sv
// Shared register map, bit positions and prescaler select encodings for the
// avr_io_timer8 peripheral.
package avr_io_pkg;

  localparam logic [2:0] TCCR_OFS  = 3'd0;
  localparam logic [2:0] TCNT_OFS  = 3'd1;
  localparam logic [2:0] OCR_OFS   = 3'd2;
  localparam logic [2:0] TIFR_OFS  = 3'd3;
  localparam logic [2:0] TIMSK_OFS = 3'd4;

  localparam int CS_LSB  = 0;
  localparam int CS_MSB  = 2;
  localparam int CTC_BIT = 3;
  localparam int COM_BIT = 4;
  localparam int TOV_BIT = 0;
  localparam int OCF_BIT = 1;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5,
    CS_RSV6    = 3'd6,
    CS_RSV7    = 3'd7
  } cs_e;

  // Terminal count of the prescaler for a given select (divisor - 1).
  function automatic logic [9:0] cs_last(input logic [2:0] cs);
    case (cs)
      CS_DIV8:    cs_last = 10'd7;
      CS_DIV64:   cs_last = 10'd63;
      CS_DIV256:  cs_last = 10'd255;
      CS_DIV1024: cs_last = 10'd1023;
      default:    cs_last = 10'd0;
    endcase
  endfunction

  function automatic logic cs_running(input logic [2:0] cs);
    case (cs)
      CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: cs_running = 1'b1;
      default:                                           cs_running = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/avr_io_timer8_prescaler.sv
// Clock prescaler: 10-bit up-counter producing a one-cycle tick every N clocks
// for the selected divisor; held at zero while stopped or on clr.
module avr_prescaler
  import avr_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs,
  input  logic       clr,
  output logic       tick
);

  logic [9:0] cnt;
  logic [9:0] last;
  logic       run;

  assign last = cs_last(cs);
  assign run  = cs_running(cs);
  assign tick = run && (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/avr_io_timer8.sv
// 8-bit timer/counter responder on the AVR I/O bus with overflow and compare
// flags; compare output pin is built only when AVR_TIMER_OC_EN is defined.
module avr_io_timer8
  import avr_io_pkg::*;
#(
  parameter logic [5:0] BASE_ADDR = 6'h20,
  parameter logic [7:0] RST_OCR   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] io_addr,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       io_sel,
  output logic       irq,
  output logic       oc
);

  logic [5:0] ofs;
  logic [2:0] reg_ofs;
  logic       wr, wr_tccr, wr_tcnt, wr_ocr, wr_tifr, wr_timsk;
  logic [3:0] tccr_lo;
  logic       com;
  logic [7:0] tccr_rd;
  logic [7:0] tcnt, ocr;
  logic       tov, ocf;
  logic [1:0] timsk;
  logic       tick, cnt_tick, match, ocf_set, tov_set;
  logic       unused_read;

  // Reads have no side effects, so the read strobe carries no information here.
  assign unused_read = io_read;

  assign ofs      = io_addr - BASE_ADDR;
  assign io_sel   = (ofs < 6'd5);
  assign reg_ofs  = ofs[2:0];
  assign wr       = io_write & io_sel;
  assign wr_tccr  = wr && (reg_ofs == TCCR_OFS);
  assign wr_tcnt  = wr && (reg_ofs == TCNT_OFS);
  assign wr_ocr   = wr && (reg_ofs == OCR_OFS);
  assign wr_tifr  = wr && (reg_ofs == TIFR_OFS);
  assign wr_timsk = wr && (reg_ofs == TIMSK_OFS);

  avr_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cs   (tccr_lo[CS_MSB:CS_LSB]),
    .clr  (wr_tccr),
    .tick (tick)
  );

  // A CPU write to TCNT swallows the tick, including its compare/overflow.
  assign cnt_tick = tick & ~wr_tcnt;
  assign match    = (tcnt == ocr);
  assign ocf_set  = cnt_tick & match;
  assign tov_set  = cnt_tick & ~(match & tccr_lo[CTC_BIT]) & (tcnt == 8'hFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tccr_lo <= '0;
      tcnt    <= '0;
      ocr     <= RST_OCR;
      tov     <= 1'b0;
      ocf     <= 1'b0;
      timsk   <= '0;
    end else begin
      if (wr_tccr)  tccr_lo <= io_din[3:0];
      if (wr_ocr)   ocr     <= io_din;
      if (wr_timsk) timsk   <= io_din[1:0];
      if (wr_tcnt) begin
        tcnt <= io_din;
      end else if (cnt_tick) begin
        tcnt <= (match && tccr_lo[CTC_BIT]) ? 8'h00 : tcnt + 8'd1;
      end
      // Hardware set takes priority over a same-cycle write-1-clear.
      tov <= tov_set | (tov & ~(wr_tifr & io_din[TOV_BIT]));
      ocf <= ocf_set | (ocf & ~(wr_tifr & io_din[OCF_BIT]));
    end
  end

`ifdef AVR_TIMER_OC_EN
  logic oc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com  <= 1'b0;
      oc_q <= 1'b0;
    end else begin
      if (wr_tccr)         com  <= io_din[COM_BIT];
      if (ocf_set && com)  oc_q <= ~oc_q;
    end
  end

  assign oc = oc_q;
`else
  assign com = 1'b0;
  assign oc  = 1'b0;
`endif

  always_comb begin
    tccr_rd          = '0;
    tccr_rd[3:0]     = tccr_lo;
    tccr_rd[COM_BIT] = com;
  end

  always_comb begin
    io_dout = '0;
    if (io_sel) begin
      case (reg_ofs)
        TCCR_OFS:  io_dout = tccr_rd;
        TCNT_OFS:  io_dout = tcnt;
        OCR_OFS:   io_dout = ocr;
        TIFR_OFS: begin
          io_dout[TOV_BIT] = tov;
          io_dout[OCF_BIT] = ocf;
        end
        TIMSK_OFS: io_dout = {6'b0, timsk};
        default:   io_dout = '0;
      endcase
    end
  end

  assign irq = |({ocf, tov} & timsk);

endmodule

// File: tb/tb_avr_io_timer8.sv
// Self-checking bench for avr_io_timer8: directed register vectors, timing
// corner sequences and randomized bus traffic against a behavioural model.
module tb_avr_io_timer8;

  localparam logic [5:0] BASE = 6'h20;
`ifdef AVR_TIMER_OC_EN
  localparam bit         OC_ON     = 1'b1;
  localparam logic [7:0] TCCR_MASK = 8'h1F;
`else
  localparam bit         OC_ON     = 1'b0;
  localparam logic [7:0] TCCR_MASK = 8'h0F;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] io_addr;
  logic       io_read, io_write;
  logic [7:0] io_din, io_dout;
  logic       io_sel, irq, oc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avr_io_timer8 #(.BASE_ADDR(BASE), .RST_OCR(8'hFF)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_read(io_read),
    .io_write(io_write), .io_din(io_din), .io_dout(io_dout),
    .io_sel(io_sel), .irq(irq), .oc(oc)
  );

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_tccr, m_tcnt, m_ocr;
  logic       m_tov, m_ocf, m_oc;
  logic [1:0] m_timsk;
  int         m_phase;

  function automatic int divisor(input logic [2:0] cs);
    case (cs)
      3'd1:    return 1;
      3'd2:    return 8;
      3'd3:    return 64;
      3'd4:    return 256;
      3'd5:    return 1024;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_tccr = 8'h00; m_tcnt = 8'h00; m_ocr = 8'hFF;
    m_tov = 1'b0; m_ocf = 1'b0; m_oc = 1'b0; m_timsk = 2'b00; m_phase = 0;
  endtask

  task automatic model_step(input logic w, input logic [5:0] addr, input logic [7:0] d);
    int  div, off, nxt;
    bit  mapped, tick, hit, set_ocf, set_tov;
    off     = int'(addr) - int'(BASE);
    mapped  = (off >= 0) && (off < 5);
    div     = divisor(m_tccr[2:0]);
    tick    = (div != 0) && (m_phase == div - 1);
    hit     = 1'b0;
    set_ocf = 1'b0;
    set_tov = 1'b0;
    if (w && mapped && off == 1) begin
      m_tcnt = d;
    end else if (tick) begin
      hit     = (m_tcnt == m_ocr);
      set_ocf = hit;
      if (hit && m_tccr[3]) begin
        m_tcnt = 8'h00;
      end else begin
        nxt     = int'(m_tcnt) + 1;
        set_tov = (nxt == 256);
        m_tcnt  = 8'(nxt % 256);
      end
      if (OC_ON && hit && m_tccr[4]) m_oc = ~m_oc;
    end
    if ((w && mapped && off == 0) || div == 0) m_phase = 0;
    else                                       m_phase = (m_phase + 1) % div;
    if (w && mapped && off == 3) begin
      if (d[0]) m_tov = 1'b0;
      if (d[1]) m_ocf = 1'b0;
    end
    if (set_tov) m_tov = 1'b1;
    if (set_ocf) m_ocf = 1'b1;
    if (w && mapped && off == 0) m_tccr  = d & TCCR_MASK;
    if (w && mapped && off == 2) m_ocr   = d;
    if (w && mapped && off == 4) m_timsk = d[1:0];
  endtask

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0:       return m_tccr;
      1:       return m_tcnt;
      2:       return m_ocr;
      3:       return {6'b0, m_ocf, m_tov};
      4:       return {6'b0, m_timsk};
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- bench helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic [5:0] addr, input logic [7:0] d);
    io_addr  = addr;
    io_din   = d;
    io_write = w;
    @(posedge clk);
    model_step(w, addr, d);
    #1;
    io_write = 1'b0;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    cyc(1'b1, BASE + 6'(off), d);
  endtask

  task automatic idle();
    cyc(1'b0, BASE + 6'd1, 8'h00);
  endtask

  task automatic rd(input int off, input logic [7:0] exp, input string name);
    io_addr = BASE + 6'(off);
    io_read = 1'b1;
    #1;
    check8(name, io_dout, exp);
    io_read = 1'b0;
  endtask

  task automatic do_reset();
    io_write = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [5:0] raddr;
    logic [7:0] exp;
    logic       exp_sel;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    io_addr = 6'h00; io_read = 1'b0; io_write = 1'b0; io_din = 8'h00; rst = 1'b0;
    model_reset();

    vecs[0]  = '{6'h20, 8'hF8, 6'h20, (OC_ON ? 8'h18 : 8'h08), 1'b1};
    vecs[1]  = '{6'h22, 8'h55, 6'h22, 8'h55, 1'b1};
    vecs[2]  = '{6'h24, 8'hFE, 6'h24, 8'h02, 1'b1};
    vecs[3]  = '{6'h21, 8'hA5, 6'h21, 8'hA5, 1'b1};
    vecs[4]  = '{6'h25, 8'h77, 6'h22, 8'h55, 1'b1};
    vecs[5]  = '{6'h1F, 8'h00, 6'h21, 8'hA5, 1'b1};
    vecs[6]  = '{6'h23, 8'hFF, 6'h23, 8'h00, 1'b1};
    vecs[7]  = '{6'h20, 8'h06, 6'h20, 8'h06, 1'b1};
    vecs[8]  = '{6'h3F, 8'h12, 6'h21, 8'hA5, 1'b1};
    vecs[9]  = '{6'h26, 8'h34, 6'h1F, 8'h00, 1'b0};
    vecs[10] = '{6'h24, 8'h00, 6'h24, 8'h00, 1'b1};
    vecs[11] = '{6'h20, 8'h07, 6'h21, 8'hA5, 1'b1};

    // Reset values
    do_reset();
    rd(0, 8'h00, "rst_tccr");
    rd(1, 8'h00, "rst_tcnt");
    rd(2, 8'hFF, "rst_ocr");
    rd(3, 8'h00, "rst_tifr");
    rd(4, 8'h00, "rst_timsk");
    check1("rst_irq", irq, 1'b0);
    check1("rst_oc", oc, 1'b0);
    rd(5, 8'h00, "unmapped_dout");
    check1("unmapped_sel", io_sel, 1'b0);

    // Register vectors with the timer stopped
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, vecs[i].addr, vecs[i].wdata);
      io_addr = vecs[i].raddr;
      #1;
      check8($sformatf("vec%0d_dout", i), io_dout, vecs[i].exp);
      check1($sformatf("vec%0d_sel", i), io_sel, vecs[i].exp_sel);
    end

    // Overflow with /1
    do_reset();
    wr(1, 8'hFD);
    wr(4, 8'h01);
    wr(0, 8'h01);
    rd(1, 8'hFD, "ovf_tcnt0");
    idle(); rd(1, 8'hFE, "ovf_tcnt1");
    idle(); rd(1, 8'hFF, "ovf_tcnt2");
    check1("ovf_irq_before", irq, 1'b0);
    idle(); rd(1, 8'h00, "ovf_tcnt3");
    rd(3, 8'h03, "ovf_tifr");
    check1("ovf_irq", irq, 1'b1);
    wr(3, 8'h01);
    rd(3, 8'h02, "ovf_tifr_clr");
    check1("ovf_irq_clr", irq, 1'b0);

    // CTC with /8, OCR=3
    do_reset();
    wr(2, 8'h03);
    wr(0, 8'h0A);
    for (int j = 1; j <= 63; j++) begin
      idle();
      if (j == 7) rd(1, 8'h00, "ctc_hold7");
      if (j % 8 == 0) rd(1, 8'((j / 8) % 4), $sformatf("ctc_tcnt_%0d", j));
      if (j == 31) rd(3, 8'h00, "ctc_tifr31");
      if (j == 32) rd(3, 8'h02, "ctc_tifr32");
    end
    wr(3, 8'h02);
    rd(3, 8'h02, "ctc_set_beats_clr");
    rd(1, 8'h00, "ctc_tcnt64");
    wr(3, 8'h02);
    rd(3, 8'h00, "ctc_clr");

    // TCNT write on a matching tick
    do_reset();
    wr(2, 8'h05);
    wr(1, 8'h05);
    wr(0, 8'h01);
    wr(1, 8'h10);
    rd(1, 8'h10, "wr_wins_tcnt");
    rd(3, 8'h00, "wr_wins_tifr");
    idle();
    rd(1, 8'h11, "wr_wins_next");

    // Compare output toggle
    do_reset();
    wr(2, 8'h02);
    wr(4, 8'h02);
    wr(0, 8'h19);
    for (int j = 1; j <= 9; j++) begin
      idle();
      check1($sformatf("oc_%0d", j), oc, OC_ON ? logic'((j / 3) % 2) : 1'b0);
      if (j == 3) check1("oc_irq", irq, 1'b1);
      if (j == 4) rd(1, 8'h01, "oc_tcnt4");
    end
    wr(0, 8'h09);
    for (int j = 0; j < 6; j++) idle();
    check1("oc_hold", oc, OC_ON);

    // Mid-run reset
    rst = 1'b0;
    #1;
    rd(1, 8'h00, "midrst_tcnt");
    check1("midrst_irq", irq, 1'b0);
    check1("midrst_oc", oc, 1'b0);
    do_reset();
    idle();
    rd(1, 8'h00, "midrst_stopped");
    rd(2, 8'hFF, "midrst_ocr");

    // Randomized traffic against the model
    do_reset();
    wr(0, 8'h01);
    for (int n = 0; n < 2000; n++) begin
      int off;
      logic [5:0] a;
      logic [7:0] d;
      off = int'($urandom_range(0, 5));
      rd(1, model_read(1), "rnd_tcnt");
      rd(3, model_read(3), "rnd_tifr");
      rd(off, model_read(off), "rnd_reg");
      check1("rnd_irq", irq, |({m_ocf, m_tov} & m_timsk));
      check1("rnd_oc", oc, m_oc);
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 7) == 0) ? 6'h1F : BASE + 6'($urandom_range(0, 5));
        d = 8'($urandom);
        if (a == BASE && $urandom_range(0, 3) != 0) d[2:0] = 3'($urandom_range(1, 2));
        cyc(1'b1, a, d);
      end else begin
        idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
